// File: rtl/serial_pattern_tx_if.sv
// Handshake and status bundle for serial_pattern_tx.
// The continuous-retransmit request is named rep because "repeat" is a
// reserved SystemVerilog keyword.
interface serial_pattern_tx_if;
    logic       start;
    logic       stop;
    logic [7:0] data;
    logic [2:0] len;
    logic       rep;
    logic       x;
    logic [1:0] S;
    logic       busy;
    logic       done;
    logic [2:0] bit_cnt;

    modport master (
        output start, stop, data, len, rep,
        input  x, S, busy, done, bit_cnt
    );

    modport slave (
        input  start, stop, data, len, rep,
        output x, S, busy, done, bit_cnt
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: latches an 1..8 bit pattern and shifts it out
// MSB first on x, optionally repeating until stop. Outputs are Moore-decoded
// from registers only.
module serial_pattern_tx (
    input  logic                 CLK,
    input  logic                 RESET,
    serial_pattern_tx_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] data_q;
    logic [2:0] len_q;
    logic       rep_q;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       capture;
    logic       abort;

    // A start only counts in IDLE and loses to a simultaneous stop.
    assign capture = (state == IDLE) && bus.start && !bus.stop;
    assign abort   = (state != IDLE) && bus.stop;

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    // Next-state decode; stop overrides every other transition.
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:  if (capture) state_nxt = LOAD;
            LOAD:  state_nxt = bus.stop ? IDLE : SHIFT;
            SHIFT: begin
                if (bus.stop)              state_nxt = IDLE;
                else if (bit_cnt == 3'd0)  state_nxt = DONE;
            end
            DONE: begin
                if (bus.stop)   state_nxt = IDLE;
                else if (rep_q) state_nxt = LOAD;
                else            state_nxt = IDLE;
            end
        endcase
    end

    // Pattern capture, shift register and remaining-bit counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: every register here is a small flop, not a memory, so all
            // of them (including the latched pattern) take the async reset.
            data_q  <= 8'h00;
            len_q   <= 3'd0;
            rep_q   <= 1'b0;
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
        end else begin
            if (capture) begin
                data_q <= bus.data;
                len_q  <= bus.len;
                rep_q  <= bus.rep;
            end
            if (abort) begin
                shreg   <= 8'h00;
                bit_cnt <= 3'd0;
            end else if (state == LOAD) begin
                // Left-justify the pattern so its MSB sits in shreg[7].
                shreg   <= data_q << (3'd7 - len_q);
                bit_cnt <= len_q;
            end else if (state == SHIFT && bit_cnt != 3'd0) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt - 3'd1;
            end
        end
    end

    assign bus.x       = (state == SHIFT) ? shreg[7] : 1'b0;
    assign bus.S       = state;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.bit_cnt = bit_cnt;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one task per scenario, inline checks.
module tb_serial_pattern_tx;

    logic CLK = 1'b0;
    logic RESET;

    serial_pattern_tx_if bus ();

    serial_pattern_tx dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET     = 1'b1;
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        bus.data  = 8'hFF;
        bus.len   = 3'd7;
        bus.rep   = 1'b1;
        #1;
        total_cnt++;
        if ({bus.S, bus.x, bus.busy, bus.done, bus.bit_cnt} !== 8'h00)
            $display("FAIL reset_t0: got %b want 00000000", {bus.S, bus.x, bus.busy, bus.done, bus.bit_cnt});
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if ({bus.S, bus.x, bus.busy, bus.done, bus.bit_cnt} !== 8'h00)
            $display("FAIL reset_held: got %b want 00000000", {bus.S, bus.x, bus.busy, bus.done, bus.bit_cnt});
        else pass_cnt++;
        bus.start = 1'b0;
        RESET     = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({bus.S, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL reset_release: got %b want 0000", {bus.S, bus.busy, bus.done});
        else pass_cnt++;
    endtask

    task automatic test_b2_full();
        logic [7:0] pat;
        int busy_cycles;
        pat = 8'hB2;
        busy_cycles = 0;
        bus.data = 8'hB2; bus.len = 3'd7; bus.rep = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.data = 8'h00; bus.len = 3'd0;
        if (bus.busy) busy_cycles++;
        total_cnt++;
        if ({bus.S, bus.x, bus.busy} !== 4'b0101)
            $display("FAIL b2_load: got %b want 0101", {bus.S, bus.x, bus.busy});
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.busy) busy_cycles++;
            total_cnt++;
            if ({bus.S, bus.x} !== {2'b10, pat[7-i]})
                $display("FAIL b2_bit%0d: got %b want %b", i, {bus.S, bus.x}, {2'b10, pat[7-i]});
            else pass_cnt++;
        end
        tick();
        if (bus.busy) busy_cycles++;
        total_cnt++;
        if ({bus.S, bus.x, bus.done} !== 4'b1101)
            $display("FAIL b2_done: got %b want 1101", {bus.S, bus.x, bus.done});
        else pass_cnt++;
        tick();
        if (bus.busy) busy_cycles++;
        total_cnt++;
        if ({bus.S, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL b2_idle: got %b want 0000", {bus.S, bus.busy, bus.done});
        else pass_cnt++;
        total_cnt++;
        if (busy_cycles !== 10)
            $display("FAIL b2_busy_len: got %0d want 10", busy_cycles);
        else pass_cnt++;
    endtask

    task automatic test_fd_short();
        logic [7:0] pat;
        int busy_cycles;
        pat = 8'hFD;
        busy_cycles = 0;
        bus.data = 8'hFD; bus.len = 3'd2; bus.rep = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.busy) busy_cycles++;
            if (c >= 1 && c <= 3) begin
                total_cnt++;
                if ({bus.S, bus.x, bus.bit_cnt} !== {2'b10, pat[3-c], 3'(3-c)})
                    $display("FAIL fd_shift%0d: got %b want %b", c - 1,
                             {bus.S, bus.x, bus.bit_cnt}, {2'b10, pat[3-c], 3'(3-c)});
                else pass_cnt++;
            end
            tick();
        end
        total_cnt++;
        if (busy_cycles !== 5)
            $display("FAIL fd_busy_len: got %0d want 5", busy_cycles);
        else pass_cnt++;
    endtask

    task automatic test_repeat();
        logic [3:0] xs;
        logic [3:0] ds;
        xs = 4'b1100;
        ds = 4'b0010;
        bus.data = 8'h03; bus.len = 3'd1; bus.rep = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.rep = 1'b0;
        total_cnt++;
        if (bus.S !== 2'b01)
            $display("FAIL rep_load: got %b want 01", bus.S);
        else pass_cnt++;
        for (int c = 0; c < 12; c++) begin
            tick();
            total_cnt++;
            if ({bus.x, bus.done} !== {xs[3-(c%4)], ds[3-(c%4)]})
                $display("FAIL rep_cycle%0d: got %b want %b", c, {bus.x, bus.done},
                         {xs[3-(c%4)], ds[3-(c%4)]});
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({bus.S, bus.x} !== 3'b101)
            $display("FAIL rep_shift_again: got %b want 101", {bus.S, bus.x});
        else pass_cnt++;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        total_cnt++;
        if ({bus.S, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL rep_stop: got %b want 0000", {bus.S, bus.busy, bus.done});
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++;
            if ({bus.S, bus.done} !== 3'b000)
                $display("FAIL rep_after_stop%0d: got %b want 000", c, {bus.S, bus.done});
            else pass_cnt++;
        end
    endtask

    task automatic test_stop_in_done();
        bus.data = 8'h03; bus.len = 3'd1; bus.rep = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({bus.S, bus.done} !== 3'b111)
            $display("FAIL stopdone_pre: got %b want 111", {bus.S, bus.done});
        else pass_cnt++;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        total_cnt++;
        if ({bus.S, bus.done} !== 3'b000)
            $display("FAIL stopdone_idle: got %b want 000", {bus.S, bus.done});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.S !== 2'b00)
            $display("FAIL stopdone_stay: got %b want 00", bus.S);
        else pass_cnt++;
        bus.rep = 1'b0;
    endtask

    task automatic test_start_stop_idle();
        bus.data = 8'hFF; bus.len = 3'd7; bus.start = 1'b1; bus.stop = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total_cnt++;
            if ({bus.S, bus.busy} !== 3'b000)
                $display("FAIL startstop%0d: got %b want 000", c, {bus.S, bus.busy});
            else pass_cnt++;
        end
        bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic test_ignore_start();
        bus.data = 8'h00; bus.len = 3'd7; bus.rep = 1'b0; bus.start = 1'b1;
        tick();
        bus.data = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) bus.start = 1'b0;
            total_cnt++;
            if ({bus.S, bus.x} !== 3'b100)
                $display("FAIL busy_zero%0d: got %b want 100", i, {bus.S, bus.x});
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (bus.done !== 1'b1)
            $display("FAIL busy_done: got %b want 1", bus.done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.S !== 2'b00)
            $display("FAIL busy_no_capture: got %b want 00", bus.S);
        else pass_cnt++;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++;
            if ({bus.S, bus.x} !== 3'b101)
                $display("FAIL ff_bit%0d: got %b want 101", i, {bus.S, bus.x});
            else pass_cnt++;
        end
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        bus.data = 8'hB2; bus.len = 3'd7; bus.rep = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        total_cnt++;
        if ({bus.S, bus.x, bus.bit_cnt} !== 6'b101111)
            $display("FAIL areset_pre: got %b want 101111", {bus.S, bus.x, bus.bit_cnt});
        else pass_cnt++;
        #2 RESET = 1'b1;
        #1;
        total_cnt++;
        if ({bus.S, bus.x, bus.busy, bus.done, bus.bit_cnt} !== 8'h00)
            $display("FAIL areset_async: got %b want 00000000",
                     {bus.S, bus.x, bus.busy, bus.done, bus.bit_cnt});
        else pass_cnt++;
        #4 RESET = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total_cnt++;
            if ({bus.S, bus.busy, bus.done} !== 4'b0000)
                $display("FAIL areset_after%0d: got %b want 0000", c, {bus.S, bus.busy, bus.done});
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_b2_full();
        test_fd_short();
        test_repeat();
        test_stop_in_done();
        test_start_stop_idle();
        test_ignore_start();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
